// File: rtl/axi_rd_stream.sv
// AXI-3 read master: splits a contiguous bus-aligned region into 4 KB-safe INCR
// bursts and streams the returned beats to a valid/ready consumer.
module axi_rd_stream #(
  parameter int AXI_RD_ID_WIDTH        = 8,
  parameter int AXI_RD_ADDR_WIDTH      = 32,
  parameter int AXI_RD_BUS_WIDTH       = 64,
  parameter int AXI_RD_MAX_BURST_LEN   = 16,
  parameter int AXI_RD_MAX_OUTSTANDING = 4,
  parameter int BEATS_WIDTH            = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [AXI_RD_ID_WIDTH-1:0]   id,
  input  logic [AXI_RD_ADDR_WIDTH-1:0] addr,
  input  logic [BEATS_WIDTH-1:0]       beats,
  output logic [1:0]                   status,
  output logic [AXI_RD_BUS_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [AXI_RD_ID_WIDTH-1:0]   ar_id,
  output logic [AXI_RD_ADDR_WIDTH-1:0] ar_addr,
  output logic [3:0]                   ar_len,
  output logic [2:0]                   ar_size,
  output logic [1:0]                   ar_burst,
  output logic [2:0]                   ar_prot,
  output logic                         ar_valid,
  input  logic                         ar_ready,
  input  logic [AXI_RD_ID_WIDTH-1:0]   r_id,
  input  logic [AXI_RD_BUS_WIDTH-1:0]  r_data,
  input  logic [1:0]                   r_resp,
  input  logic                         r_last,
  input  logic                         r_valid,
  output logic                         r_ready
);

  localparam int BYTES = AXI_RD_BUS_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int OW    = $clog2(AXI_RD_MAX_OUTSTANDING + 1);
  localparam logic [AXI_RD_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_RD_ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_OK = 2'd2, ST_ERR = 2'd3} state_t;

  state_t                       status_reg;
  logic                         ar_valid_reg;
  logic [AXI_RD_ADDR_WIDTH-1:0] ar_addr_reg;
  logic [3:0]                   ar_len_reg;
  logic [AXI_RD_ID_WIDTH-1:0]   ar_id_reg;
  logic [AXI_RD_ADDR_WIDTH-1:0] next_addr_reg;
  logic [BEATS_WIDTH-1:0]       beats_reg;
  logic [BEATS_WIDTH-1:0]       remaining_reg;
  logic [BEATS_WIDTH-1:0]       received_reg;
  logic [OW-1:0]                outstanding_reg;
  logic [4:0]                   burst_n_reg;
  logic                         err_reg;

  logic [12:0] to_boundary_bytes;
  logic [12:0] to_boundary_beats;
  logic [4:0]  burst_n;
  logic        busy;
  logic        ar_hs;
  logic        beat_hs;
  logic        last_hs;
  logic        final_beat;
  logic        unused_bits;

  assign busy       = (status_reg == ST_BUSY);
  assign ar_hs      = ar_valid_reg && ar_ready;
  assign r_ready    = out_ready && busy;
  assign beat_hs    = r_valid && r_ready;
  assign last_hs    = beat_hs && r_last;
  assign final_beat = (received_reg == beats_reg - BEATS_WIDTH'(1));

  assign out_data  = r_data;
  assign out_valid = r_valid && busy;
  assign out_last  = out_valid && final_beat;

  assign status   = status_reg;
  assign ar_id    = ar_id_reg;
  assign ar_addr  = ar_addr_reg;
  assign ar_len   = ar_len_reg;
  assign ar_valid = ar_valid_reg;
  assign ar_size  = 3'(SIZE);
  assign ar_burst = 2'b01;
  assign ar_prot  = 3'b000;

  assign unused_bits = ^{r_id, r_resp[0]};

  // Next burst is limited by what is left, the max burst length and the 4 KB page edge.
  assign to_boundary_bytes = 13'd4096 - {1'b0, next_addr_reg[11:0]};
  assign to_boundary_beats = to_boundary_bytes >> SIZE;

  always_comb begin
    burst_n = 5'(AXI_RD_MAX_BURST_LEN);
    if (remaining_reg < BEATS_WIDTH'(AXI_RD_MAX_BURST_LEN))
      burst_n = 5'(remaining_reg);
    if (to_boundary_beats < 13'(burst_n))
      burst_n = 5'(to_boundary_beats);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_reg      <= ST_IDLE;
      ar_valid_reg    <= 1'b0;
      ar_addr_reg     <= '0;
      ar_len_reg      <= '0;
      ar_id_reg       <= '0;
      next_addr_reg   <= '0;
      beats_reg       <= '0;
      remaining_reg   <= '0;
      received_reg    <= '0;
      outstanding_reg <= '0;
      burst_n_reg     <= '0;
      err_reg         <= 1'b0;
    end else begin
      case (status_reg)
        ST_IDLE: begin
          if (enable) begin
            ar_id_reg       <= id;
            next_addr_reg   <= addr & ALIGN_MASK;
            beats_reg       <= beats;
            remaining_reg   <= beats;
            received_reg    <= '0;
            outstanding_reg <= '0;
            err_reg         <= 1'b0;
            status_reg      <= (beats == '0) ? ST_OK : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!ar_valid_reg && remaining_reg != '0 &&
              outstanding_reg < OW'(AXI_RD_MAX_OUTSTANDING)) begin
            ar_addr_reg  <= next_addr_reg;
            ar_len_reg   <= 4'(burst_n - 5'd1);
            burst_n_reg  <= burst_n;
            ar_valid_reg <= 1'b1;
          end
          if (ar_hs) begin
            ar_valid_reg  <= 1'b0;
            next_addr_reg <= next_addr_reg + (AXI_RD_ADDR_WIDTH'(burst_n_reg) << SIZE);
            remaining_reg <= remaining_reg - BEATS_WIDTH'(burst_n_reg);
          end
          // A burst issued and a burst retired in the same cycle cancel out.
          if (ar_hs && !last_hs)
            outstanding_reg <= outstanding_reg + OW'(1);
          else if (!ar_hs && last_hs)
            outstanding_reg <= outstanding_reg - OW'(1);
          if (beat_hs) begin
            received_reg <= received_reg + BEATS_WIDTH'(1);
            if (r_resp[1])
              err_reg <= 1'b1;
            if (final_beat)
              status_reg <= (err_reg || r_resp[1]) ? ST_ERR : ST_OK;
          end
        end
        default: begin
          if (!enable)
            status_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
